// File: rtl/led_s2p_rx.sv
// Serial-to-parallel receiver for the LED shift chain: oversamples sclk/sclrn/sin/EN and publishes a word on the EN latch.
// Optional LED_S2P_GLITCH_FILTER_EN: an sclk/EN edge counts only after the synced level has held for 2 clk.
module led_s2p_rx #(
  parameter int DATA_BITS       = 16,
  parameter int DATA_COUNT_BITS = 5,
  parameter bit DIR             = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sclk,
  input  logic                 sclrn,
  input  logic                 sin,
  input  logic                 EN,
  output logic [DATA_BITS-1:0] PData,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy,
  output logic [1:0]           state_dbg
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SHIFT = 2'd1, S_FULL = 2'd2, S_OVR = 2'd3} state_t;

  // [0] first sync stage, [1] synced level, [2] previous synced level for edge detect
  logic [2:0] sclk_q;
  logic [2:0] en_q;
  logic [1:0] sin_q;
  logic [1:0] sclrn_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_q  <= '0;
      en_q    <= '0;
      sin_q   <= '0;
      sclrn_q <= 2'b11;
    end else begin
      sclk_q  <= {sclk_q[1:0], sclk};
      en_q    <= {en_q[1:0], EN};
      sin_q   <= {sin_q[0], sin};
      sclrn_q <= {sclrn_q[0], sclrn};
    end
  end

  logic sclk_rise;
  logic en_rise;

`ifdef LED_S2P_GLITCH_FILTER_EN
  // Filtered levels follow the synced line only once it has been stable for two samples
  logic sclk_f_q;
  logic en_f_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_f_q <= 1'b0;
      en_f_q   <= 1'b0;
    end else begin
      if (sclk_q[1] == sclk_q[2]) sclk_f_q <= sclk_q[2];
      if (en_q[1] == en_q[2])     en_f_q   <= en_q[2];
    end
  end

  assign sclk_rise = sclk_q[1] & sclk_q[2] & ~sclk_f_q;
  assign en_rise   = en_q[1] & en_q[2] & ~en_f_q;
`else
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign en_rise   = en_q[1] & ~en_q[2];
`endif

  state_t                     state_q, state_d;
  logic [DATA_BITS-1:0]       sr_q, sr_d;
  logic [DATA_COUNT_BITS-1:0] cnt_q, cnt_d;
  logic [DATA_BITS-1:0]       pdata_q, pdata_d;
  logic                       valid_q, valid_d;
  logic                       err_q, err_d;
  logic [DATA_COUNT_BITS-1:0] cnt_inc;

  assign cnt_inc = cnt_q + DATA_COUNT_BITS'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      pdata_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      pdata_q <= pdata_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  // Priority: serial clear, then latch, then shift; a shift coinciding with a latch is dropped
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    pdata_d = pdata_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    if (!sclrn_q[1]) begin
      state_d = S_IDLE;
      sr_d    = '0;
      cnt_d   = '0;
    end else if (en_rise) begin
      if (state_q == S_FULL) begin
        pdata_d = sr_q;
        valid_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
      state_d = S_IDLE;
      sr_d    = '0;
      cnt_d   = '0;
    end else if (sclk_rise && state_q != S_OVR) begin
      if (DIR == 1'b0) sr_d = {sr_q[DATA_BITS-2:0], sin_q[1]};
      else             sr_d = {sin_q[1], sr_q[DATA_BITS-1:1]};
      cnt_d = cnt_inc;
      if (state_q == S_FULL)                             state_d = S_OVR;
      else if (cnt_inc == DATA_COUNT_BITS'(DATA_BITS))  state_d = S_FULL;
      else                                               state_d = S_SHIFT;
    end
  end

  assign PData     = pdata_q;
  assign valid     = valid_q;
  assign frame_err = err_q;
  assign busy      = (state_q != S_IDLE);
  assign state_dbg = state_q;

endmodule
